// File: rtl/onchip_mem_pattern_tester_pkg.sv
// Shared types and constants for the on-chip RAM pattern tester.
// The LFSR helper is used by the pattern generator.
package onchip_mem_pattern_tester_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] PAT_ADDR  = 2'b00;
    localparam logic [1:0] PAT_NADDR = 2'b01;
    localparam logic [1:0] PAT_LFSR  = 2'b10;
    localparam logic [1:0] PAT_CONST = 2'b11;

    // Taps 32,22,2,1 expressed as a bit mask over state bits 31,21,1,0.
    localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
    localparam logic [31:0] LFSR_ZERO_SEED = 32'h0000_0001;

    // XNOR feedback gives the 1, 2, 4, ... start from the substitute seed.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ~(^(s & LFSR_TAPS))};
    endfunction

endpackage

// File: rtl/onchip_mem_pattern_gen.sv
// Pattern word generator: address, inverted address, LFSR or constant.
// The LFSR reloads on load and steps once per issued word on adv.
module onchip_mem_pattern_gen
    import onchip_mem_pattern_tester_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              adv,
    input  logic [1:0]        mode,
    input  logic [31:0]       seed,
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       pattern
);

    logic [31:0] lfsr_q, lfsr_d;

    // Load wins over advance so the last word of a pass can rearm the generator.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == 32'h0) ? LFSR_ZERO_SEED : seed;
        end else if (adv) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_ZERO_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        pattern = seed;
        case (mode)
            PAT_ADDR:  pattern = 32'(addr);
            PAT_NADDR: pattern = ~32'(addr);
            PAT_LFSR:  pattern = lfsr_q;
            default:   pattern = seed;
        endcase
    end

endmodule

// File: rtl/onchip_mem_pattern_tester.sv
// Avalon-MM write-then-verify engine for the 4096x32 on-chip RAM.
// Fills every word with a pattern, reads it back and records mismatches.
module onchip_mem_pattern_tester
    import onchip_mem_pattern_tester_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [31:0]       first_err_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    // Handshake: the RAM has no waitrequest; one access per cycle while
    // chipselect is high, and readdata is valid exactly one cycle after address.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0]         mode_q, mode_d;
    logic [31:0]        seed_q, seed_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               first_seen_q, first_seen_d;
    logic [ADDR_W-1:0]  fea_q, fea_d;
    logic [31:0]        fed_q, fed_d;
    logic               pass_q, pass_d;
    logic [DATA_W-1:0]  cmp_exp_q;
    logic [ADDR_W-1:0]  cmp_addr_q;
    logic               cmp_vld_q;
    logic               gen_load, gen_adv, mismatch;
    logic [31:0]        gen_seed, pattern;

    // In IDLE the generator must see the live seed so it loads on the start cycle.
    assign gen_seed = (state_q == IDLE) ? seed : seed_q;
    assign mismatch = cmp_vld_q && (mem_readdata != cmp_exp_q);

    onchip_mem_pattern_gen #(.ADDR_W(ADDR_W)) u_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (gen_load),
        .adv     (gen_adv),
        .mode    (mode_q),
        .seed    (gen_seed),
        .addr    (addr_q),
        .pattern (pattern)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        mode_d       = mode_q;
        seed_d       = seed_q;
        err_cnt_d    = err_cnt_q;
        first_seen_d = first_seen_q;
        fea_d        = fea_q;
        fed_d        = fed_q;
        pass_d       = pass_q;
        gen_load     = 1'b0;
        gen_adv      = 1'b0;

        if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (!first_seen_q) begin
                first_seen_d = 1'b1;
                fea_d        = cmp_addr_q;
                fed_d        = mem_readdata;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    seed_d       = seed;
                    err_cnt_d    = '0;
                    first_seen_d = 1'b0;
                    fea_d        = '0;
                    fed_d        = '0;
                    pass_d       = 1'b0;
                    gen_load     = 1'b1;
                    addr_d       = '0;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                gen_adv = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    addr_d   = '0;
                    gen_load = 1'b1;
                    state_d  = READ;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            READ: begin
                gen_adv = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // The final compare lands in err_cnt_d this cycle.
                pass_d  = (err_cnt_d == '0);
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            mode_q       <= PAT_ADDR;
            seed_q       <= '0;
            err_cnt_q    <= '0;
            first_seen_q <= 1'b0;
            fea_q        <= '0;
            fed_q        <= '0;
            pass_q       <= 1'b0;
            cmp_exp_q    <= '0;
            cmp_addr_q   <= '0;
            cmp_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            mode_q       <= mode_d;
            seed_q       <= seed_d;
            err_cnt_q    <= err_cnt_d;
            first_seen_q <= first_seen_d;
            fea_q        <= fea_d;
            fed_q        <= fed_d;
            pass_q       <= pass_d;
            cmp_exp_q    <= pattern;
            cmp_addr_q   <= addr_q;
            cmp_vld_q    <= (state_q == READ);
        end
    end

    assign busy           = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign pass           = pass_q;
    assign err_count      = err_cnt_q;
    assign first_err_addr = fea_q;
    assign first_err_data = fed_q;
    assign mem_address    = addr_q;
    assign mem_byteenable = 4'hF;
    assign mem_chipselect = (state_q == WRITE) || (state_q == READ);
    assign mem_write      = (state_q == WRITE);
    assign mem_writedata  = (state_q == WRITE) ? pattern : '0;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_pattern_tester.sv
// Bench for onchip_mem_pattern_tester: three instances (full size, small with
// a 4-bit error counter, single word) each backed by a fault-injecting RAM model.
module tb_onchip_mem_pattern_tester;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset_n;
    logic [NI-1:0]         start_v;
    logic [1:0]            mode_i;
    logic [31:0]           seed_i;
    logic [NI-1:0]         busy_v, done_v, pass_v, cs_v, we_v, clken_v;
    logic [NI-1:0][3:0]    be_v;
    logic [NI-1:0][15:0]   errc_v;
    logic [NI-1:0][11:0]   fea_v, addr_v;
    logic [NI-1:0][31:0]   fed_v, wd_v, rd_v;

    // RAM models: registered read, optional per-word bit flips or all-zero reads.
    logic [31:0] mem  [NI][4096];
    logic [31:0] flip [NI][4096];
    logic [NI-1:0] zero_rd;

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (cs_v[k]) begin
                if (we_v[k]) mem[k][addr_v[k]] <= wd_v[k];
                else rd_v[k] <= zero_rd[k] ? 32'h0 : (mem[k][addr_v[k]] ^ flip[k][addr_v[k]]);
            end
        end
    end

    onchip_mem_pattern_tester #(.ADDR_W(12), .DATA_W(32), .DEPTH(4096), .ERR_W(16)) dut_big (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .mode(mode_i), .seed(seed_i),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(errc_v[0]),
        .first_err_addr(fea_v[0]), .first_err_data(fed_v[0]), .mem_address(addr_v[0]),
        .mem_byteenable(be_v[0]), .mem_chipselect(cs_v[0]), .mem_write(we_v[0]),
        .mem_writedata(wd_v[0]), .mem_clken(clken_v[0]), .mem_readdata(rd_v[0])
    );

    onchip_mem_pattern_tester #(.ADDR_W(12), .DATA_W(32), .DEPTH(16), .ERR_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .mode(mode_i), .seed(seed_i),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(errc_v[1][3:0]),
        .first_err_addr(fea_v[1]), .first_err_data(fed_v[1]), .mem_address(addr_v[1]),
        .mem_byteenable(be_v[1]), .mem_chipselect(cs_v[1]), .mem_write(we_v[1]),
        .mem_writedata(wd_v[1]), .mem_clken(clken_v[1]), .mem_readdata(rd_v[1])
    );
    assign errc_v[1][15:4] = '0;

    onchip_mem_pattern_tester #(.ADDR_W(12), .DATA_W(32), .DEPTH(1), .ERR_W(16)) dut_one (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .mode(mode_i), .seed(seed_i),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(errc_v[2]),
        .first_err_addr(fea_v[2]), .first_err_data(fed_v[2]), .mem_address(addr_v[2]),
        .mem_byteenable(be_v[2]), .mem_chipselect(cs_v[2]), .mem_write(we_v[2]),
        .mem_writedata(wd_v[2]), .mem_clken(clken_v[2]), .mem_readdata(rd_v[2])
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: pattern words straight from the pattern rules.
    logic [31:0] words [4096];
    logic [43:0] exp_q [$];
    int          wr_bad, wr_n;
    logic [31:0] wr_first [2];

    function automatic logic [31:0] ref_lfsr_next(input logic [31:0] s);
        return {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
    endfunction

    task automatic build_model(input int depth, input logic [1:0] m, input logic [31:0] sd);
        logic [31:0] s;
        s = (sd == 32'h0) ? 32'h1 : sd;
        for (int a = 0; a < depth; a++) begin
            case (m)
                2'b00: words[a] = 32'(a);
                2'b01: words[a] = ~32'(a);
                2'b10: begin words[a] = s; s = ref_lfsr_next(s); end
                default: words[a] = sd;
            endcase
        end
    endtask

    task automatic model_result(input int k, input int depth, input int errmax,
                                output int e, output bit p, output int fa, output logic [31:0] fd);
        logic [31:0] rd;
        int cnt;
        cnt = 0; fa = 0; fd = 32'h0;
        for (int a = 0; a < depth; a++) begin
            rd = zero_rd[k] ? 32'h0 : (words[a] ^ flip[k][a]);
            if (rd != words[a]) begin
                if (cnt == 0) begin fa = a; fd = rd; end
                cnt++;
            end
        end
        e = (cnt > errmax) ? errmax : cnt;
        p = (cnt == 0);
    endtask

    task automatic set_faults(input int k, input int fa0, input logic [31:0] fm0,
                              input int fa1, input logic [31:0] fm1, input bit z);
        for (int a = 0; a < 4096; a++) flip[k][a] = 32'h0;
        if (fa0 >= 0) flip[k][fa0] = fm0;
        if (fa1 >= 0) flip[k][fa1] = fm1;
        zero_rd[k] = z;
    endtask

    task automatic sample_write(input int k);
        logic [43:0] e;
        if (cs_v[k] && we_v[k]) begin
            if (exp_q.size() == 0) wr_bad++;
            else begin
                e = exp_q.pop_front();
                if (e !== {addr_v[k], wd_v[k]}) wr_bad++;
            end
            if (wr_n < 2) wr_first[wr_n] = wd_v[k];
            wr_n++;
        end
    endtask

    // One full test on instance k; optional second start pulse at cycle restart_at.
    task automatic run_test(input int k, input int depth, input logic [1:0] m, input logic [31:0] sd,
                            input int restart_at, input int exp_err, input bit exp_pass,
                            input int exp_fa, input logic [31:0] exp_fd, input string tag);
        int c;
        build_model(depth, m, sd);
        exp_q.delete();
        for (int a = 0; a < depth; a++) exp_q.push_back({12'(a), words[a]});
        wr_bad = 0; wr_n = 0; wr_first[0] = 32'h0; wr_first[1] = 32'h0;
        @(negedge clk);
        mode_i = m; seed_i = sd; start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        mode_i = 2'($urandom); seed_i = $urandom;
        c = 1;
        while (!done_v[k] && c < 3 * depth + 20) begin
            sample_write(k);
            start_v[k] = (c == restart_at);
            @(negedge clk);
            c++;
        end
        start_v[k] = 1'b0;
        chk({tag, " latency"}, 64'(c), 64'(2 * depth + 2));
        chk({tag, " err_count"}, 64'(errc_v[k]), 64'(exp_err));
        chk({tag, " pass"}, 64'(pass_v[k]), 64'(exp_pass));
        chk({tag, " first_err_addr"}, 64'(fea_v[k]), 64'(exp_fa));
        chk({tag, " first_err_data"}, 64'(fed_v[k]), 64'(exp_fd));
        chk({tag, " write stream"}, {32'(wr_bad), 32'(exp_q.size())}, 64'h0);
        @(negedge clk);
        chk({tag, " idle busy/done/pass"}, {61'h0, busy_v[k], done_v[k], pass_v[k]}, {61'h0, 2'b00, exp_pass});
    endtask

    typedef struct {
        int          k;
        int          depth;
        logic [1:0]  mode;
        logic [31:0] seed;
        int          fa0;
        logic [31:0] fm0;
        int          fa1;
        logic [31:0] fm1;
        bit          zero;
        int          restart;
        int          exp_err;
        bit          exp_pass;
        int          exp_fa;
        logic [31:0] exp_fd;
        logic [31:0] exp_w0;
        logic [31:0] exp_w1;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, fa;
        bit p;
        logic [31:0] fd;
        logic [1:0] rm;
        logic [31:0] rs;
        string tag;

        tbl[0] = '{0, 4096, 2'b00, 32'h0,        -1, 32'h0,   -1, 32'h0, 1'b0, -1,  0, 1'b1,  0, 32'h0,        32'h0,        32'h1};
        tbl[1] = '{0, 4096, 2'b10, 32'h0,        -1, 32'h0,   -1, 32'h0, 1'b0, -1,  0, 1'b1,  0, 32'h0,        32'h1,        32'h2};
        tbl[2] = '{0, 4096, 2'b01, 32'h0,        42, 32'h1,   -1, 32'h0, 1'b0, -1,  1, 1'b0, 42, 32'hFFFFFFD4, 32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[3] = '{0, 4096, 2'b11, 32'hDEADBEEF,  5, 32'h100,  9, 32'h1, 1'b0, -1,  2, 1'b0,  5, 32'hDEADBFEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[4] = '{0, 4096, 2'b00, 32'h5,        -1, 32'h0,   -1, 32'h0, 1'b0, 100, 0, 1'b1,  0, 32'h0,        32'h0,        32'h1};
        tbl[5] = '{1, 16,   2'b01, 32'h0,        -1, 32'h0,   -1, 32'h0, 1'b1, -1, 15, 1'b0,  0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[6] = '{2, 1,    2'b10, 32'h1234,     -1, 32'h0,   -1, 32'h0, 1'b0, -1,  0, 1'b1,  0, 32'h0,        32'h1234,     32'h0};

        // Clock/reset block.
        reset_n = 1'b0; start_v = '0; mode_i = 2'b00; seed_i = 32'h0; zero_rd = '0;
        for (int k = 0; k < NI; k++) set_faults(k, -1, 32'h0, -1, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset status", {busy_v, done_v, pass_v, errc_v[0], fea_v[0]}, 64'h0);
        chk("reset first_err_data", 64'(fed_v[0]), 64'h0);
        chk("reset mem bus", {18'h0, addr_v[0], cs_v[0], we_v[0], wd_v[0]}, 64'h0);
        chk("constant byteenable/clken", {49'h0, be_v, clken_v}, {49'h0, 12'hFFF, 3'b111});
        reset_n = 1'b1;
        @(negedge clk);

        // Table-driven directed tests.
        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("row%0d", i);
            set_faults(tbl[i].k, tbl[i].fa0, tbl[i].fm0, tbl[i].fa1, tbl[i].fm1, tbl[i].zero);
            run_test(tbl[i].k, tbl[i].depth, tbl[i].mode, tbl[i].seed, tbl[i].restart,
                     tbl[i].exp_err, tbl[i].exp_pass, tbl[i].exp_fa, tbl[i].exp_fd, tag);
            chk({tag, " first write word"}, 64'(wr_first[0]), 64'(tbl[i].exp_w0));
            if (tbl[i].depth > 1) chk({tag, " second write word"}, 64'(wr_first[1]), 64'(tbl[i].exp_w1));
            if (i == 0) chk("row0 ram word 100", 64'(mem[0][100]), 64'h64);
        end

        // Reset in the middle of READ, with an error already counted.
        set_faults(0, 3, 32'h8, -1, 32'h0, 1'b0);
        @(negedge clk);
        mode_i = 2'b00; seed_i = 32'h0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4096 + 20) @(negedge clk);
        chk("mid-read busy and err", {47'h0, busy_v[0], errc_v[0]}, {47'h0, 1'b1, 16'h1});
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid-test reset status", {busy_v, done_v, pass_v, errc_v[0], fea_v[0]}, 64'h0);
        chk("mid-test reset first_err_data", 64'(fed_v[0]), 64'h0);
        chk("mid-test reset mem bus", {18'h0, addr_v[0], cs_v[0], we_v[0], wd_v[0]}, 64'h0);
        reset_n = 1'b1;
        set_faults(0, -1, 32'h0, -1, 32'h0, 1'b0);
        run_test(0, 4096, 2'b10, 32'h600DF00D, -1, 0, 1'b1, 0, 32'h0, "post-reset");

        // Randomized runs on the small instance against the reference model.
        for (int r = 0; r < 10; r++) begin
            tag = $sformatf("rand%0d", r);
            rm = 2'($urandom_range(0, 3));
            rs = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            set_faults(1,
                       ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 15)),
                       32'h1 << $urandom_range(0, 31),
                       ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 15)),
                       32'h1 << $urandom_range(0, 31),
                       ($urandom_range(0, 4) == 0));
            build_model(16, rm, rs);
            model_result(1, 16, 15, e, p, fa, fd);
            run_test(1, 16, rm, rs, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(2, 30)),
                     e, p, fa, fd, tag);
            chk({tag, " first write words"}, {wr_first[0], wr_first[1]}, {words[0], words[1]});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
